// File: rtl/write_buffer.sv
// Serializes a captured WIDTH*WORDS line into WIDTH-bit words, lowest first; 1-cycle load latency.
// STEP advances one word per edge; LOAD is ignored while a line is in flight.
module write_buffer #(
  parameter int WIDTH = 32,
  parameter int WORDS = 8
) (
  input  logic                       DRAMCLK,
  input  logic                       RESET,
  input  logic                       LOAD,
  input  logic [WIDTH*WORDS-1:0]     dIn,
  input  logic                       STEP,
  output logic [WIDTH-1:0]           dOut,
  output logic                       VALID,
  output logic                       BUSY,
  output logic                       DONE,
  output logic [$clog2(WORDS)-1:0]   WORDIDX
);

  localparam int LW = WIDTH * WORDS;
  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state, state_nxt;
  logic [LW-1:0]   line_q, line_nxt;
  logic [IW-1:0]   idx_q, idx_nxt;
  logic            done_q, done_nxt;

  always_ff @(posedge DRAMCLK or negedge RESET) begin
    if (!RESET) begin
      state  <= IDLE;
      line_q <= '0;
      idx_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      line_q <= line_nxt;
      idx_q  <= idx_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    line_nxt  = line_q;
    idx_nxt   = idx_q;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        // A STEP coinciding with LOAD is dropped; the new line starts at word 0.
        if (LOAD) begin
          line_nxt  = dIn;
          idx_nxt   = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (STEP) begin
          line_nxt = {{WIDTH{1'b0}}, line_q[LW-1:WIDTH]};
          if (idx_q == LAST_IDX) begin
            idx_nxt   = '0;
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt = idx_q + IW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The register is zero after the last shift, so dOut needs no IDLE gating.
  assign dOut    = line_q[WIDTH-1:0];
  assign VALID   = (state == SEND);
  assign BUSY    = (state == SEND);
  assign DONE    = done_q;
  assign WORDIDX = idx_q;

endmodule

// File: tb/tb_write_buffer.sv
// Randomized bench for write_buffer against a queue-based model of the word stream.
module tb_write_buffer;
  localparam int WIDTH = 32;
  localparam int WORDS = 8;
  localparam int LW = WIDTH * WORDS;

  logic          DRAMCLK = 1'b0;
  logic          RESET = 1'b0;
  logic          LOAD = 1'b0;
  logic [LW-1:0] dIn = '0;
  logic          STEP = 1'b0;
  logic [WIDTH-1:0] dOut;
  logic          VALID, BUSY, DONE;
  logic [2:0]    WORDIDX;

  write_buffer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .DRAMCLK(DRAMCLK), .RESET(RESET), .LOAD(LOAD), .dIn(dIn), .STEP(STEP),
    .dOut(dOut), .VALID(VALID), .BUSY(BUSY), .DONE(DONE), .WORDIDX(WORDIDX)
  );

  always #5 DRAMCLK = ~DRAMCLK;

  int checks = 0;
  int failures = 0;
  int dones = 0;
  int busy_cycles = 0;

  // Model: a line in flight is the queue of words not yet consumed.
  bit               m_busy = 1'b0;
  bit               m_done = 1'b0;
  logic [WIDTH-1:0] m_q[$];
  logic [LW-1:0]    m_line = '0;
  logic [WIDTH-1:0] rx[$];

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < WORDS; i++) l[i*WIDTH +: WIDTH] = $urandom;
    return l;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_done = 1'b0;
    m_q.delete();
    rx.delete();
  endtask

  task automatic compare(input string ph);
    logic [WIDTH-1:0] exp_dout;
    int exp_idx;
    exp_dout = '0;
    exp_idx = 0;
    if (m_busy) begin
      exp_dout = m_q[0];
      exp_idx = WORDS - m_q.size();
    end
    chk({ph, ".dout"}, LW'(dOut), LW'(exp_dout));
    chk({ph, ".valid"}, LW'(VALID), LW'(m_busy));
    chk({ph, ".busy"}, LW'(BUSY), LW'(m_busy));
    chk({ph, ".done"}, LW'(DONE), LW'(m_done));
    chk({ph, ".wordidx"}, LW'(WORDIDX), LW'(exp_idx));
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic cyc(input string ph, input logic ld, input logic [LW-1:0] d, input logic st);
    logic [LW-1:0] got;
    LOAD = ld;
    dIn = d;
    STEP = st;
    if (m_busy && st && RESET) rx.push_back(dOut);
    @(posedge DRAMCLK);
    m_done = 1'b0;
    if (!RESET) begin
      model_reset();
    end else if (!m_busy) begin
      if (ld) begin
        m_line = d;
        for (int i = 0; i < WORDS; i++) m_q.push_back(d[i*WIDTH +: WIDTH]);
        m_busy = 1'b1;
        rx.delete();
      end
    end else if (st) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        chk({ph, ".rx_count"}, LW'(rx.size()), LW'(WORDS));
        got = '0;
        for (int i = 0; i < rx.size() && i < WORDS; i++) got[i*WIDTH +: WIDTH] = rx[i];
        chk({ph, ".roundtrip"}, got, m_line);
        rx.delete();
      end
    end
    #1;
    compare(ph);
    if (DONE) dones++;
    if (BUSY) busy_cycles++;
  endtask

  initial begin
    logic [LW-1:0] ramp, la, lb;
    for (int i = 0; i < WORDS; i++) ramp[i*WIDTH +: WIDTH] = i * 32'h11111111;

    // Reset and idle behaviour.
    #3;
    compare("reset");
    @(posedge DRAMCLK);
    #1;
    compare("reset_hold");
    RESET = 1'b1;
    for (int k = 0; k < 5; k++) cyc("idle_step", 1'b0, ramp, k[0]);

    // Basic line with STEP held high.
    busy_cycles = 0;
    dones = 0;
    cyc("basic_load", 1'b1, ramp, 1'b0);
    for (int k = 0; k < WORDS; k++) cyc("basic_step", 1'b0, '0, 1'b1);
    cyc("basic_after", 1'b0, '0, 1'b0);
    chk("basic_busy_cycles", LW'(busy_cycles), LW'(WORDS));
    chk("basic_done_count", LW'(dones), 1);

    // Stalled handshake: STEP every third cycle.
    dones = 0;
    cyc("stall_load", 1'b1, ramp, 1'b0);
    for (int k = 0; k < 40 && m_busy; k++) cyc("stall", 1'b0, '0, (k % 3) == 2);
    chk("stall_timeout", LW'(m_busy), 0);
    cyc("stall_after", 1'b0, '0, 1'b0);
    chk("stall_done_count", LW'(dones), 1);

    // LOAD while in flight at WORDIDX=3 must not disturb the line.
    la = rand_line();
    cyc("ovl_load", 1'b1, la, 1'b0);
    for (int k = 0; k < 3; k++) cyc("ovl_step", 1'b0, '0, 1'b1);
    cyc("ovl_load_busy", 1'b1, ~la, 1'b0);
    cyc("ovl_load_step", 1'b1, ~la, 1'b1);
    for (int k = 0; k < 40 && m_busy; k++) cyc("ovl_drain", 1'b0, '0, 1'b1);
    cyc("ovl_after", 1'b0, '0, 1'b0);

    // LOAD and STEP together in IDLE: the STEP is dropped.
    cyc("ldstep", 1'b1, rand_line(), 1'b1);
    for (int k = 0; k < 40 && m_busy; k++) cyc("ldstep_drain", 1'b0, '0, 1'b1);

    // Back-to-back: line B loads in A's DONE cycle, then reset at WORDIDX=5.
    la = rand_line();
    lb = rand_line();
    cyc("b2b_a", 1'b1, la, 1'b0);
    for (int k = 0; k < WORDS; k++) cyc("b2b_a_step", 1'b0, '0, 1'b1);
    chk("b2b_done_seen", LW'(DONE), 1);
    cyc("b2b_b", 1'b1, lb, 1'b0);
    for (int k = 0; k < 5; k++) cyc("b2b_b_step", 1'b0, '0, 1'b1);
    dones = 0;
    #2;
    RESET = 1'b0;
    #1;
    model_reset();
    compare("async_reset");
    cyc("reset_held", 1'b0, '0, 1'b1);
    cyc("reset_held", 1'b1, lb, 1'b1);
    RESET = 1'b1;
    for (int k = 0; k < 3; k++) cyc("post_reset", 1'b0, '0, 1'b1);
    chk("reset_no_done", LW'(dones), 0);

    // Random traffic with round-trip reassembly of every line.
    for (int k = 0; k < 600; k++)
      cyc("rand", ($urandom_range(0, 3) == 0), rand_line(), ($urandom_range(0, 2) != 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
